peg_l2_mac_tx_framer: RTL and testbench



---
 rtl/peg_l2_mac_tx_framer.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_peg_l2_mac_tx_framer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peg_l2_mac_tx_framer.sv
// -----------------------------------------------------------------------------
// peg_l2_mac_tx_framer
//   Frames MAC TX payload words for the RMII RS TX stage. Every frame gets one
//   preamble/SFD word in front. Short frames are zero-padded to MIN_FRM_B bytes.
//   When PEG_L2_MAC_TX_FCS_EN is defined, a CRC-32 FCS is appended right after
//   the last payload/pad byte.
//
//   Optional feature macro: PEG_L2_MAC_TX_FCS_EN (undefined = no CRC, no FCS).
//
// Ports
//   rmii_ref_clk  in   clock, shared with RS TX
//   rst           in   synchronous active-high reset
//   in_valid/in_sop/in_eop/in_data/in_size/in_error  payload word in
//   in_ready      out  payload word accepted when in_valid & in_ready
//   pkt_valid/pkt_sop/pkt_eop/pkt_data/pkt_size/pkt_error  registered framed word
//   pkt_ready     in   RS TX accepts the current framed word
// -----------------------------------------------------------------------------
module peg_l2_mac_tx_framer #(
    parameter int PKT_DATA_W = 64,
    parameter int PKT_SIZE_W = 16,
    parameter int MIN_FRM_B  = 60
) (
    input  logic                  rmii_ref_clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic [PKT_DATA_W-1:0] in_data,
    input  logic [PKT_SIZE_W-1:0] in_size,
    input  logic                  in_error,
    output logic                  in_ready,
    output logic                  pkt_valid,
    output logic                  pkt_sop,
    output logic                  pkt_eop,
    output logic [PKT_DATA_W-1:0] pkt_data,
    output logic [PKT_SIZE_W-1:0] pkt_size,
    output logic                  pkt_error,
    input  logic                  pkt_ready
);

    localparam logic [63:0]           PREAMBLE = 64'hD555_5555_5555_5555;
    localparam logic [PKT_SIZE_W-1:0] MIN_B    = PKT_SIZE_W'(MIN_FRM_B);
    localparam logic [PKT_SIZE_W-1:0] W8       = PKT_SIZE_W'(8);
    localparam logic [PKT_SIZE_W-1:0] W64      = PKT_SIZE_W'(64);
`ifdef PEG_L2_MAC_TX_FCS_EN
    localparam logic [PKT_SIZE_W-1:0] W4       = PKT_SIZE_W'(4);
`endif

    typedef enum logic [1:0] {IDLE_S, DATA_S, PAD_S, FCS_S} state_t;

    // Keep bytes [n-1:0] of a word, zero the rest.
    function automatic logic [63:0] keep_bytes(input logic [63:0] d,
                                               input logic [PKT_SIZE_W-1:0] n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (PKT_SIZE_W'(i) < n) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Byte counter add that sticks at all-ones instead of wrapping.
    function automatic logic [PKT_SIZE_W-1:0] sat_add(input logic [PKT_SIZE_W-1:0] a,
                                                      input logic [PKT_SIZE_W-1:0] b);
        logic [PKT_SIZE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[PKT_SIZE_W] ? '1 : s[PKT_SIZE_W-1:0];
    endfunction

`ifdef PEG_L2_MAC_TX_FCS_EN
    // Reflected CRC-32 (0x04C11DB7 -> 0xEDB88320), first n bytes, LSB byte first.
    function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                            input logic [63:0] d,
                                            input logic [PKT_SIZE_W-1:0] n);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (PKT_SIZE_W'(i) < n) begin
                r = r ^ {24'd0, d[8*i +: 8]};
                for (int b = 0; b < 8; b++)
                    r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
            end
        end
        return r;
    endfunction
`endif

    state_t                state;
    logic [PKT_SIZE_W-1:0] byte_cnt;
    logic                  err_q;
`ifdef PEG_L2_MAC_TX_FCS_EN
    logic [31:0]           crc_q;
    logic [31:0]           fcs_res_q;
    logic [PKT_SIZE_W-1:0] res_bytes_q;
    logic                  final_word;
    logic [31:0]           crc_step;
    logic [31:0]           fcs;
    logic [31:0]           fcs_res;
    logic [PKT_SIZE_W-1:0] res_bytes;
`endif

    logic                  ld_en;
    logic                  accept;
    logic [PKT_SIZE_W-1:0] in_bytes;
    logic [63:0]           data_m;
    logic [PKT_SIZE_W-1:0] word_end;
    logic [PKT_SIZE_W-1:0] tot;
    logic                  pad_need;
    logic                  pad_last;
    logic                  err_now;
    logic [63:0]           fin_data;
    logic [PKT_SIZE_W-1:0] fin_bytes;
    logic [63:0]           fin_out_data;
    logic                  fin_out_eop;
    logic [PKT_SIZE_W-1:0] fin_out_size;
    state_t                fin_next;

    // The output register is free when empty or being drained this cycle.
    assign ld_en    = ~pkt_valid | pkt_ready;
    assign in_ready = (state == DATA_S) & ld_en;
    assign accept   = in_valid & in_ready;

    // NOTE: every output of this block gets a value on every path; a missed
    // default here would silently infer a latch.
    always_comb begin
        in_bytes = in_eop ? (in_size >> 3) : W8;
        data_m   = keep_bytes(in_data, in_bytes);
        word_end = sat_add(byte_cnt, W8);
        tot      = sat_add(byte_cnt, in_bytes);
        // Pad words are needed only if this word cannot itself reach the minimum.
        pad_need = (tot < MIN_B) && (word_end < MIN_B);
        pad_last = (word_end >= MIN_B);
        err_now  = err_q | (accept & in_error);

        // Word carrying the last payload/pad byte and its byte count.
        if (state == PAD_S) begin
            fin_data  = '0;
            fin_bytes = MIN_B - byte_cnt;
        end else begin
            fin_data  = data_m;
            fin_bytes = (tot < MIN_B) ? (MIN_B - byte_cnt) : in_bytes;
        end

`ifdef PEG_L2_MAC_TX_FCS_EN
        final_word   = (state == PAD_S) ? pad_last : (in_eop & ~pad_need);
        crc_step     = crc_upd(crc_q, fin_data, final_word ? fin_bytes : W8);
        // Errored frames get a deliberately wrong (inverted) FCS.
        fcs          = ~crc_step ^ {32{err_now}};
        fin_out_data = fin_data | ({32'd0, fcs} << (fin_bytes << 3));
        fcs_res      = fcs >> ((W8 - fin_bytes) << 3);
        res_bytes    = fin_bytes - W4;
        if (fin_bytes <= W4) begin
            fin_out_eop  = 1'b1;
            fin_out_size = (fin_bytes + W4) << 3;
            fin_next     = IDLE_S;
        end else begin
            fin_out_eop  = 1'b0;
            fin_out_size = W64;
            fin_next     = FCS_S;
        end
`else
        fin_out_data = fin_data;
        fin_out_eop  = 1'b1;
        fin_out_size = fin_bytes << 3;
        fin_next     = IDLE_S;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; later assignments in this block override the
    // default "pkt_valid <= 0" when a word is loaded.
    always_ff @(posedge rmii_ref_clk) begin
        if (rst) begin
            state       <= IDLE_S;
            byte_cnt    <= '0;
            err_q       <= 1'b0;
            pkt_valid   <= 1'b0;
            pkt_sop     <= 1'b0;
            pkt_eop     <= 1'b0;
            pkt_data    <= '0;
            pkt_size    <= '0;
            pkt_error   <= 1'b0;
`ifdef PEG_L2_MAC_TX_FCS_EN
            crc_q       <= 32'hFFFF_FFFF;
            fcs_res_q   <= '0;
            res_bytes_q <= '0;
`endif
        end else begin
            if (ld_en) pkt_valid <= 1'b0;

            case (state)
                IDLE_S: begin
                    byte_cnt <= '0;
                    err_q    <= 1'b0;
`ifdef PEG_L2_MAC_TX_FCS_EN
                    crc_q    <= 32'hFFFF_FFFF;
`endif
                    // The sop word itself is held and consumed in DATA_S.
                    if (ld_en && in_valid && in_sop) begin
                        pkt_valid <= 1'b1;
                        pkt_sop   <= 1'b1;
                        pkt_eop   <= 1'b0;
                        pkt_data  <= PREAMBLE;
                        pkt_size  <= W64;
                        pkt_error <= 1'b0;
                        state     <= DATA_S;
                    end
                end

                DATA_S: begin
                    if (accept) begin
                        err_q     <= err_now;
                        byte_cnt  <= word_end;
                        pkt_valid <= 1'b1;
                        pkt_sop   <= 1'b0;
`ifdef PEG_L2_MAC_TX_FCS_EN
                        crc_q     <= crc_step;
`endif
                        if (in_eop && !pad_need) begin
                            pkt_data  <= fin_out_data;
                            pkt_eop   <= fin_out_eop;
                            pkt_size  <= fin_out_size;
                            pkt_error <= fin_out_eop & err_now;
                            state     <= fin_next;
`ifdef PEG_L2_MAC_TX_FCS_EN
                            fcs_res_q   <= fcs_res;
                            res_bytes_q <= res_bytes;
`endif
                        end else begin
                            pkt_data  <= data_m;
                            pkt_eop   <= 1'b0;
                            pkt_size  <= W64;
                            pkt_error <= 1'b0;
                            if (in_eop) state <= PAD_S;
                        end
                    end
                end

                PAD_S: begin
                    if (ld_en) begin
                        byte_cnt  <= word_end;
                        pkt_valid <= 1'b1;
                        pkt_sop   <= 1'b0;
`ifdef PEG_L2_MAC_TX_FCS_EN
                        crc_q     <= crc_step;
`endif
                        if (pad_last) begin
                            pkt_data  <= fin_out_data;
                            pkt_eop   <= fin_out_eop;
                            pkt_size  <= fin_out_size;
                            pkt_error <= fin_out_eop & err_q;
                            state     <= fin_next;
`ifdef PEG_L2_MAC_TX_FCS_EN
                            fcs_res_q   <= fcs_res;
                            res_bytes_q <= res_bytes;
`endif
                        end else begin
                            pkt_data  <= '0;
                            pkt_eop   <= 1'b0;
                            pkt_size  <= W64;
                            pkt_error <= 1'b0;
                        end
                    end
                end

`ifdef PEG_L2_MAC_TX_FCS_EN
                FCS_S: begin
                    // Residual word: FCS bytes that did not fit the last word.
                    if (ld_en) begin
                        pkt_valid <= 1'b1;
                        pkt_sop   <= 1'b0;
                        pkt_eop   <= 1'b1;
                        pkt_data  <= {32'd0, fcs_res_q};
                        pkt_size  <= res_bytes_q << 3;
                        pkt_error <= err_q;
                        state     <= IDLE_S;
                    end
                end
`endif

                default: state <= IDLE_S;
            endcase
        end
    end

endmodule

// File: tb/tb_peg_l2_mac_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_peg_l2_mac_tx_framer
//   Directed + randomized bench for peg_l2_mac_tx_framer. Expected frames are
//   built from a byte-level model: payload, zero pad to 60 bytes, optional FCS,
//   then cut into 8-byte words behind one preamble word.
// -----------------------------------------------------------------------------
module tb_peg_l2_mac_tx_framer;

    localparam logic [63:0] PRE = 64'hD555_5555_5555_5555;

    logic        rmii_ref_clk = 1'b0;
    logic        rst;
    logic        in_valid, in_sop, in_eop, in_error;
    logic [63:0] in_data;
    logic [15:0] in_size;
    logic        in_ready;
    logic        pkt_valid, pkt_sop, pkt_eop, pkt_error;
    logic [63:0] pkt_data;
    logic [15:0] pkt_size;
    logic        pkt_ready;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [15:0] size;
        logic        err;
    } word_t;

    word_t      obs_q[$];
    word_t      exp_q[$];
    logic [7:0] pay[$];

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int timeouts = 0;
    bit stall    = 1'b0;
    bit rdy_rand = 1'b0;
    bit drv_done = 1'b0;

    peg_l2_mac_tx_framer dut (
        .rmii_ref_clk (rmii_ref_clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_sop       (in_sop),
        .in_eop       (in_eop),
        .in_data      (in_data),
        .in_size      (in_size),
        .in_error     (in_error),
        .in_ready     (in_ready),
        .pkt_valid    (pkt_valid),
        .pkt_sop      (pkt_sop),
        .pkt_eop      (pkt_eop),
        .pkt_data     (pkt_data),
        .pkt_size     (pkt_size),
        .pkt_error    (pkt_error),
        .pkt_ready    (pkt_ready)
    );

    initial forever #5 rmii_ref_clk = ~rmii_ref_clk;

    // Downstream ready: forced low, random, or always high.
    initial begin
        pkt_ready = 1'b0;
        forever begin
            @(posedge rmii_ref_clk);
            #1;
            if (stall)         pkt_ready = 1'b0;
            else if (rdy_rand) pkt_ready = ($urandom_range(0, 3) != 0);
            else               pkt_ready = 1'b1;
        end
    end

    // Record every transferred output word.
    always @(negedge rmii_ref_clk) begin
        if (!rst && pkt_valid && pkt_ready) begin
            word_t w;
            w.data = pkt_data;
            w.sop  = pkt_sop;
            w.eop  = pkt_eop;
            w.size = pkt_size;
            w.err  = pkt_error;
            obs_q.push_back(w);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Bit-serial CRC-32 over the frame bit stream, LSB of each byte first.
    function automatic logic [31:0] model_fcs(input logic [7:0] fr[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (fr[k]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ fr[k][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    task automatic make_payload(input int len, input bit ramp);
        pay.delete();
        for (int i = 0; i < len; i++)
            pay.push_back(ramp ? 8'(i) : 8'($urandom_range(0, 255)));
    endtask

    task automatic build_exp(input bit err);
        logic [7:0] fr[$];
        word_t      w;
        int         nw;
        int         nb;
        fr = pay;
        while (fr.size() < 60) fr.push_back(8'h00);
`ifdef PEG_L2_MAC_TX_FCS_EN
        begin
            logic [31:0] f;
            f = model_fcs(fr);
            if (err) f = ~f;
            for (int i = 0; i < 4; i++) fr.push_back(f[8*i +: 8]);
        end
`endif
        exp_q.delete();
        w.data = PRE; w.sop = 1'b1; w.eop = 1'b0; w.size = 16'd64; w.err = 1'b0;
        exp_q.push_back(w);
        nw = (fr.size() + 7) / 8;
        for (int wi = 0; wi < nw; wi++) begin
            nb = fr.size() - 8 * wi;
            if (nb > 8) nb = 8;
            w.data = '0;
            for (int b = 0; b < nb; b++) w.data[8*b +: 8] = fr[8*wi + b];
            w.sop  = 1'b0;
            w.eop  = (wi == nw - 1);
            w.size = w.eop ? 16'(8 * nb) : 16'd64;
            w.err  = w.eop & err;
            exp_q.push_back(w);
        end
    endtask

    // Drive the payload as words; unused bytes of the eop word carry garbage.
    task automatic drive_frame(input int err_idx);
        int nw;
        int nb;
        int t;
        logic [63:0] d;
        nw = (pay.size() + 7) / 8;
        for (int wi = 0; wi < nw; wi++) begin
            nb = pay.size() - 8 * wi;
            if (nb > 8) nb = 8;
            d = {$urandom, $urandom};
            for (int b = 0; b < nb; b++) d[8*b +: 8] = pay[8*wi + b];
            in_valid = 1'b1;
            in_sop   = (wi == 0);
            in_eop   = (wi == nw - 1);
            in_data  = d;
            in_size  = (wi == nw - 1) ? 16'(8 * nb) : 16'd64;
            in_error = (wi == err_idx);
            t = 0;
            do begin
                @(negedge rmii_ref_clk);
                t++;
            end while (!in_ready && t < 1000);
            if (t >= 1000) timeouts++;
            @(posedge rmii_ref_clk);
            #1;
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0;
        drv_done = 1'b1;
    endtask

    task automatic finish_frame(input string tag);
        int t;
        int n;
        t = 0;
        while (obs_q.size() < exp_q.size() && t < 2000) begin
            @(negedge rmii_ref_clk);
            t++;
        end
        repeat (3) @(negedge rmii_ref_clk);
        check($sformatf("%s_nwords", tag), 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_w%0d_data", tag, i), obs_q[i].data, exp_q[i].data);
            check($sformatf("%s_w%0d_sop",  tag, i), 64'(obs_q[i].sop),  64'(exp_q[i].sop));
            check($sformatf("%s_w%0d_eop",  tag, i), 64'(obs_q[i].eop),  64'(exp_q[i].eop));
            check($sformatf("%s_w%0d_size", tag, i), 64'(obs_q[i].size), 64'(exp_q[i].size));
            check($sformatf("%s_w%0d_err",  tag, i), 64'(obs_q[i].err),  64'(exp_q[i].err));
        end
    endtask

    task automatic run_frame(input string tag, input int len, input int err_idx, input bit ramp);
        make_payload(len, ramp);
        build_exp(err_idx >= 0);
        obs_q.delete();
        drv_done = 1'b0;
        drive_frame(err_idx);
        finish_frame(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(pkt_valid), 64'd0);
        check({tag, "_sop"},   64'(pkt_sop),   64'd0);
        check({tag, "_eop"},   64'(pkt_eop),   64'd0);
        check({tag, "_data"},  pkt_data,       64'd0);
        check({tag, "_size"},  64'(pkt_size),  64'd0);
        check({tag, "_error"}, 64'(pkt_error), 64'd0);
        check({tag, "_inrdy"}, 64'(in_ready),  64'd0);
    endtask

    initial begin
        logic [63:0] hold_d;
        int          t;
        int          len;
        int          eidx;

        rst = 1'b1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0;
        in_data = '0; in_size = '0;
        repeat (2) @(posedge rmii_ref_clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge rmii_ref_clk);
        #1;

        // Directed frame lengths, including pad and FCS placement boundaries.
        run_frame("t1_64b", 64, -1, 1'b0);
        run_frame("t2_14b", 14, -1, 1'b0);
        run_frame("t3_60b", 60, -1, 1'b1);
        run_frame("t4_13b", 13, -1, 1'b0);
        run_frame("t4_67b", 67, -1, 1'b0);
        run_frame("t4_70b", 70, -1, 1'b0);
        run_frame("len59",  59, -1, 1'b0);
        run_frame("len1",    1, -1, 1'b0);

        // Backpressure: hold pkt_ready low mid-frame.
        make_payload(64, 1'b0);
        build_exp(1'b0);
        obs_q.delete();
        drv_done = 1'b0;
        fork
            drive_frame(-1);
        join_none
        t = 0;
        while (obs_q.size() < 3 && t < 500) begin
            @(negedge rmii_ref_clk);
            t++;
        end
        check("t5_started", 64'(t < 500), 64'd1);
        @(posedge rmii_ref_clk);
        stall = 1'b1;
        @(negedge rmii_ref_clk);
        hold_d = pkt_data;
        check("t5_valid_at_stall", 64'(pkt_valid), 64'd1);
        repeat (5) begin
            @(negedge rmii_ref_clk);
            check("t5_hold_data",  pkt_data,       hold_d);
            check("t5_hold_valid", 64'(pkt_valid), 64'd1);
            check("t5_in_ready",   64'(in_ready),  64'd0);
        end
        stall = 1'b0;
        t = 0;
        while (!drv_done && t < 2000) begin
            @(negedge rmii_ref_clk);
            t++;
        end
        check("t5_drv_done", 64'(drv_done), 64'd1);
        finish_frame("t5_stall");

        // Error on the second word of a 64-byte frame.
        run_frame("t6_err", 64, 1, 1'b0);

        // Reset in the middle of a frame.
        obs_q.delete();
        in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_error = 1'b0;
        in_data = {$urandom, $urandom}; in_size = 16'd64;
        repeat (4) @(posedge rmii_ref_clk);
        #1;
        rst = 1'b1;
        @(posedge rmii_ref_clk);
        #1;
        check_all_zero("t6_midrst");
        rst = 1'b0;
        in_valid = 1'b0; in_sop = 1'b0;
        @(posedge rmii_ref_clk);
        #1;
        run_frame("t6_after_rst", 20, -1, 1'b0);

        // Randomized frames with random backpressure and errors.
        rdy_rand = 1'b1;
        for (int k = 0; k < 8; k++) begin
            len  = int'($urandom_range(1, 100));
            eidx = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, (len - 1) / 8)) : -1;
            run_frame($sformatf("rnd%0d", k), len, eidx, 1'b0);
        end
        rdy_rand = 1'b0;

        check("drv_timeouts", 64'(timeouts), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
